// File: rtl/arcade_ctrl_mux.sv
// Player-control front end for arcade cores: merges PS/2 keys and joystick words
// into registered active-low control bytes, with coin stretching and spinner emulation.
module arcade_ctrl_mux #(
    parameter int PLAYERS    = 2,
    parameter int DIAL_DIV   = 12000,
    parameter int COIN_PULSE = 120000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [16*PLAYERS-1:0]  joy_in,
    input  logic                   share_joy,
    input  logic [PLAYERS-1:0]     dial_en,
    input  logic [PLAYERS-1:0]     dial_rev,
    output logic [8*PLAYERS-1:0]   ctl_n
);

    localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
    localparam int DW = $clog2(DIAL_DIV);

    localparam int KEY_P1_UP    = 0;
    localparam int KEY_P1_DOWN  = 1;
    localparam int KEY_P1_LEFT  = 2;
    localparam int KEY_P1_RIGHT = 3;
    localparam int KEY_P1_FIRE1 = 4;
    localparam int KEY_P1_FIRE2 = 5;
    localparam int KEY_START1   = 6;
    localparam int KEY_START2   = 7;
    localparam int KEY_COIN1    = 8;
    localparam int KEY_COIN2    = 9;
    localparam int KEY_P2_UP    = 10;
    localparam int KEY_P2_DOWN  = 11;
    localparam int KEY_P2_LEFT  = 12;
    localparam int KEY_P2_RIGHT = 13;
    localparam int KEY_P2_FIRE1 = 14;
    localparam int NUM_KEYS     = 15;

    logic                           toggleLast_q;
    logic [NUM_KEYS-1:0]            keys_q, keys_d;
    logic [PLAYERS-1:0][CW-1:0]     coinCnt_q, coinCnt_d;
    logic [PLAYERS-1:0]             coinRawLast_q;
    logic [PLAYERS-1:0][DW-1:0]     dialDiv_q, dialDiv_d;
    logic [PLAYERS-1:0][1:0]        phase_q, phase_d;
    logic [8*PLAYERS-1:0]           ctl_q, ctl_d;

    logic [15:0]                    joyOr;
    logic [PLAYERS-1:0][8:0]        srcJoy;
    logic [PLAYERS-1:0]             upRaw, downRaw, leftRaw, rightRaw;
    logic [PLAYERS-1:0]             fire1Raw, fire2Raw, startRaw, coinRaw;
    logic [PLAYERS-1:0]             coinRise, coinOn;
    logic                           unusedBits;

    function automatic logic [1:0] stepPhase(input logic [1:0] ph, input logic fwd);
        logic [1:0] nxt;
        nxt = 2'b11;
        if (fwd) begin
            case (ph)
                2'b11:   nxt = 2'b10;
                2'b10:   nxt = 2'b00;
                2'b00:   nxt = 2'b01;
                default: nxt = 2'b11;
            endcase
        end else begin
            case (ph)
                2'b11:   nxt = 2'b01;
                2'b01:   nxt = 2'b00;
                2'b00:   nxt = 2'b10;
                default: nxt = 2'b11;
            endcase
        end
        return nxt;
    endfunction

    // The toggle latch keeps tracking during reset so a toggle coinciding with reset is consumed.
    always_ff @(posedge clk_sys) begin
        toggleLast_q <= ps2_key[10];
    end

    always_comb begin
        keys_d = keys_q;
        if (toggleLast_q != ps2_key[10]) begin
            case (ps2_key[8:0])
                9'h175:         keys_d[KEY_P1_UP]    = ps2_key[9];
                9'h172:         keys_d[KEY_P1_DOWN]  = ps2_key[9];
                9'h16B:         keys_d[KEY_P1_LEFT]  = ps2_key[9];
                9'h174:         keys_d[KEY_P1_RIGHT] = ps2_key[9];
                9'h029:         keys_d[KEY_P1_FIRE1] = ps2_key[9];
                9'h014:         keys_d[KEY_P1_FIRE2] = ps2_key[9];
                9'h005, 9'h016: keys_d[KEY_START1]   = ps2_key[9];
                9'h006, 9'h01E: keys_d[KEY_START2]   = ps2_key[9];
                9'h02E:         keys_d[KEY_COIN1]    = ps2_key[9];
                9'h036:         keys_d[KEY_COIN2]    = ps2_key[9];
                9'h02D:         keys_d[KEY_P2_UP]    = ps2_key[9];
                9'h02B:         keys_d[KEY_P2_DOWN]  = ps2_key[9];
                9'h023:         keys_d[KEY_P2_LEFT]  = ps2_key[9];
                9'h034:         keys_d[KEY_P2_RIGHT] = ps2_key[9];
                9'h01C:         keys_d[KEY_P2_FIRE1] = ps2_key[9];
                default:        ;
            endcase
        end
    end

    always_comb begin
        joyOr      = '0;
        srcJoy     = '0;
        upRaw      = '0;
        downRaw    = '0;
        leftRaw    = '0;
        rightRaw   = '0;
        fire1Raw   = '0;
        fire2Raw   = '0;
        startRaw   = '0;
        coinRaw    = '0;
        unusedBits = 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            joyOr = joyOr | joy_in[16*p +: 16];
        end
        unusedBits = ^joyOr[15:9];
        for (int p = 0; p < PLAYERS; p++) begin
            srcJoy[p]   = share_joy ? joyOr[8:0] : joy_in[16*p +: 9];
            unusedBits  = unusedBits ^ srcJoy[p][7] ^ srcJoy[p][6];
            rightRaw[p] = srcJoy[p][0];
            leftRaw[p]  = srcJoy[p][1];
            downRaw[p]  = srcJoy[p][2];
            upRaw[p]    = srcJoy[p][3];
            fire1Raw[p] = srcJoy[p][4];
            fire2Raw[p] = srcJoy[p][5];
            startRaw[p] = joy_in[16*p + 6];
            coinRaw[p]  = joy_in[16*p + 8];
            // Start buttons are global: any joystick may start player 1 or 2.
            if (p == 0) begin
                rightRaw[p] = rightRaw[p] | keys_q[KEY_P1_RIGHT];
                leftRaw[p]  = leftRaw[p]  | keys_q[KEY_P1_LEFT];
                downRaw[p]  = downRaw[p]  | keys_q[KEY_P1_DOWN];
                upRaw[p]    = upRaw[p]    | keys_q[KEY_P1_UP];
                fire1Raw[p] = fire1Raw[p] | keys_q[KEY_P1_FIRE1];
                fire2Raw[p] = fire2Raw[p] | keys_q[KEY_P1_FIRE2];
                startRaw[p] = keys_q[KEY_START1] | joyOr[6];
                coinRaw[p]  = keys_q[KEY_COIN1]  | srcJoy[p][8];
            end
            if (p == 1) begin
                rightRaw[p] = rightRaw[p] | keys_q[KEY_P2_RIGHT];
                leftRaw[p]  = leftRaw[p]  | keys_q[KEY_P2_LEFT];
                downRaw[p]  = downRaw[p]  | keys_q[KEY_P2_DOWN];
                upRaw[p]    = upRaw[p]    | keys_q[KEY_P2_UP];
                fire1Raw[p] = fire1Raw[p] | keys_q[KEY_P2_FIRE1];
                startRaw[p] = keys_q[KEY_START2] | joyOr[7];
                coinRaw[p]  = keys_q[KEY_COIN2]  | srcJoy[p][8];
            end
        end
    end

    always_comb begin
        coinCnt_d = coinCnt_q;
        dialDiv_d = '0;
        phase_d   = phase_q;
        coinRise  = '0;
        coinOn    = '0;
        ctl_d     = '1;
        for (int p = 0; p < PLAYERS; p++) begin
            // A rising edge only arms the stretcher once the previous stretch has fully expired.
            coinRise[p] = coinRaw[p] & ~coinRawLast_q[p];
            if (coinCnt_q[p] != '0) begin
                coinCnt_d[p] = coinCnt_q[p] - CW'(1);
            end else if (coinRise[p]) begin
                coinCnt_d[p] = CW'(COIN_PULSE - 1);
            end
            coinOn[p] = coinRaw[p] | (coinCnt_q[p] != '0);

            if (dial_en[p] && (upRaw[p] ^ downRaw[p])) begin
                if (dialDiv_q[p] == DW'(DIAL_DIV - 1)) begin
                    phase_d[p] = stepPhase(phase_q[p], upRaw[p] ^ dial_rev[p]);
                end else begin
                    dialDiv_d[p] = dialDiv_q[p] + DW'(1);
                end
            end

            ctl_d[8*p +: 8] = ~{fire1Raw[p], downRaw[p], upRaw[p], rightRaw[p],
                                leftRaw[p], startRaw[p], fire2Raw[p], coinOn[p]};
            if (dial_en[p]) begin
                ctl_d[8*p + 5 +: 2] = phase_d[p];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            keys_q        <= '0;
            coinCnt_q     <= '0;
            coinRawLast_q <= '0;
            dialDiv_q     <= '0;
            phase_q       <= '1;
            ctl_q         <= '1;
        end else begin
            keys_q        <= keys_d;
            coinCnt_q     <= coinCnt_d;
            coinRawLast_q <= coinRaw;
            dialDiv_q     <= dialDiv_d;
            phase_q       <= phase_d;
            ctl_q         <= ctl_d;
        end
    end

    assign ctl_n = ctl_q;

endmodule

// File: tb/tb_arcade_ctrl_mux.sv
// Testbench for arcade_ctrl_mux: directed scenarios plus randomized traffic
// checked against an event-level reference model.
module tb_arcade_ctrl_mux;

    localparam int PLAYERS    = 2;
    localparam int DIAL_DIV   = 4;
    localparam int COIN_PULSE = 5;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [31:0] joy_in = '0;
    logic        share_joy = 1'b0;
    logic [1:0]  dial_en = '0;
    logic [1:0]  dial_rev = '0;
    logic [15:0] ctl_n;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state: key states by role, coin stretch end cycle, dial hold length and position.
    int          cycleNo = 0;
    bit          mKey [15];
    bit          mLastToggle = 1'b0;
    int          stretchEnd [2] = '{-1, -1};
    bit          prevRaw [2];
    int          heldCnt [2];
    int          pos [2];
    logic [15:0] mExp = '1;
    logic [1:0]  phaseSeq [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

    always #5 clk_sys = ~clk_sys;

    arcade_ctrl_mux #(
        .PLAYERS(PLAYERS),
        .DIAL_DIV(DIAL_DIV),
        .COIN_PULSE(COIN_PULSE)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ps2_key(ps2_key),
        .joy_in(joy_in),
        .share_joy(share_joy),
        .dial_en(dial_en),
        .dial_rev(dial_rev),
        .ctl_n(ctl_n)
    );

    function automatic int keySlot(input logic [8:0] code);
        case (code)
            9'h175: return 0;
            9'h172: return 1;
            9'h16B: return 2;
            9'h174: return 3;
            9'h029: return 4;
            9'h014: return 5;
            9'h005, 9'h016: return 6;
            9'h006, 9'h01E: return 7;
            9'h02E: return 8;
            9'h036: return 9;
            9'h02D: return 10;
            9'h02B: return 11;
            9'h023: return 12;
            9'h034: return 13;
            9'h01C: return 14;
            default: return -1;
        endcase
    endfunction

    // Predicts ctl_n after the coming clock edge from the inputs currently applied.
    task automatic modelEdge();
        logic [15:0] orJ, own, src;
        bit up, down, left, right, fire1, fire2, start, raw, coin;
        logic [7:0] b;
        int slot;
        if (!reset_n) begin
            for (int k = 0; k < 15; k++) mKey[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                stretchEnd[p] = -1;
                prevRaw[p] = 1'b0;
                heldCnt[p] = 0;
                pos[p] = 0;
            end
            mExp = '1;
        end else begin
            orJ = joy_in[15:0] | joy_in[31:16];
            for (int p = 0; p < 2; p++) begin
                own = joy_in[16*p +: 16];
                src = share_joy ? orJ : own;
                if (p == 0) begin
                    up = src[3] | mKey[0];   down = src[2] | mKey[1];
                    left = src[1] | mKey[2]; right = src[0] | mKey[3];
                    fire1 = src[4] | mKey[4]; fire2 = src[5] | mKey[5];
                    start = mKey[6] | orJ[6];
                    raw = mKey[8] | src[8];
                end else begin
                    up = src[3] | mKey[10];   down = src[2] | mKey[11];
                    left = src[1] | mKey[12]; right = src[0] | mKey[13];
                    fire1 = src[4] | mKey[14]; fire2 = src[5];
                    start = mKey[7] | orJ[7];
                    raw = mKey[9] | src[8];
                end
                if (raw && !prevRaw[p] && cycleNo > stretchEnd[p])
                    stretchEnd[p] = cycleNo + COIN_PULSE - 1;
                prevRaw[p] = raw;
                coin = raw || (cycleNo <= stretchEnd[p]);
                if (dial_en[p] && (up != down)) begin
                    heldCnt[p]++;
                    if (heldCnt[p] % DIAL_DIV == 0)
                        pos[p] = (pos[p] + (((up ^ dial_rev[p]) != 0) ? 1 : 3)) % 4;
                end else begin
                    heldCnt[p] = 0;
                end
                b = ~{fire1, down, up, right, left, start, fire2, coin};
                if (dial_en[p]) b[6:5] = phaseSeq[pos[p]];
                mExp[8*p +: 8] = b;
            end
            if (ps2_key[10] != mLastToggle) begin
                slot = keySlot(ps2_key[8:0]);
                if (slot >= 0) mKey[slot] = ps2_key[9];
            end
        end
        mLastToggle = ps2_key[10];
        cycleNo++;
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic applyReset();
        joy_in = '0;
        share_joy = 1'b0;
        dial_en = '0;
        dial_rev = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        testsRun++;
        if (ctl_n !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got %h, expected %h", ctl_n, 16'hFFFF);
        end
        reset_n = 1'b1;
        tick();
        testsRun++;
        if (ctl_n !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL idle_after_reset: got %h, expected %h", ctl_n, 16'hFFFF);
        end
    endtask

    task automatic test_key_latency();
        applyReset();
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h29};
        tick();
        testsRun++;
        if (ctl_n[7] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL key_press_cycle1: got %b, expected %b", ctl_n[7], 1'b1);
        end
        tick();
        testsRun++;
        if (ctl_n[7] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL key_press_cycle2: got %b, expected %b", ctl_n[7], 1'b0);
        end
        ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h29};
        tick();
        testsRun++;
        if (ctl_n[7] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL key_release_cycle1: got %b, expected %b", ctl_n[7], 1'b0);
        end
        tick();
        testsRun++;
        if (ctl_n[7] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL key_release_cycle2: got %b, expected %b", ctl_n[7], 1'b1);
        end
    endtask

    task automatic test_share();
        applyReset();
        joy_in[16] = 1'b1;
        tick();
        testsRun++;
        if ({ctl_n[12], ctl_n[4]} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL split_joy: got %b, expected %b", {ctl_n[12], ctl_n[4]}, 2'b01);
        end
        share_joy = 1'b1;
        tick();
        testsRun++;
        if ({ctl_n[12], ctl_n[4]} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL shared_joy: got %b, expected %b", {ctl_n[12], ctl_n[4]}, 2'b00);
        end
        joy_in = '0;
        share_joy = 1'b0;
        tick();
    endtask

    task automatic test_coin();
        int lowCount;
        applyReset();
        lowCount = 0;
        for (int i = 0; i < 10; i++) begin
            joy_in[8] = (i == 0 || i == 2);
            tick();
            if (ctl_n[0] === 1'b0) lowCount++;
            if (i == 4) begin
                testsRun++;
                if (ctl_n[0] !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL coin_last_low: got %b, expected %b", ctl_n[0], 1'b0);
                end
            end
            if (i == 5) begin
                testsRun++;
                if (ctl_n[0] !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL coin_end: got %b, expected %b", ctl_n[0], 1'b1);
                end
            end
        end
        testsRun++;
        if (lowCount != COIN_PULSE) begin
            testsFailed++;
            $display("[TB] FAIL coin_length: got %0d, expected %0d", lowCount, COIN_PULSE);
        end
    endtask

    task automatic test_dial();
        logic [1:0] fwdSeq [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
        logic [1:0] revSeq [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        logic [1:0] expPh;
        for (int r = 0; r < 2; r++) begin
            applyReset();
            dial_en = 2'b01;
            dial_rev = (r == 1) ? 2'b01 : 2'b00;
            joy_in[3] = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                tick();
                expPh = (r == 1) ? revSeq[(i / 4) % 4] : fwdSeq[(i / 4) % 4];
                testsRun++;
                if (ctl_n[6:5] !== expPh) begin
                    testsFailed++;
                    $display("[TB] FAIL dial_phase rev=%0d cycle %0d: got %b, expected %b",
                             r, i, ctl_n[6:5], expPh);
                end
            end
        end
        joy_in = '0;
    endtask

    task automatic test_dial_both();
        logic [1:0] expPh;
        applyReset();
        dial_en = 2'b01;
        joy_in[3:2] = 2'b11;
        repeat (9) tick();
        testsRun++;
        if (ctl_n[6:5] !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL dial_both_frozen: got %b, expected %b", ctl_n[6:5], 2'b11);
        end
        joy_in[2] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            expPh = (i < 4) ? 2'b11 : 2'b10;
            testsRun++;
            if (ctl_n[6:5] !== expPh) begin
                testsFailed++;
                $display("[TB] FAIL dial_release_down cycle %0d: got %b, expected %b",
                         i, ctl_n[6:5], expPh);
            end
        end
        joy_in = '0;
    endtask

    task automatic test_reset_mid();
        applyReset();
        dial_en = 2'b01;
        joy_in[3] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            joy_in[8] = (i == 5);
            tick();
        end
        testsRun++;
        if ({ctl_n[6:5], ctl_n[0]} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL mid_activity: got %b, expected %b", {ctl_n[6:5], ctl_n[0]}, 3'b100);
        end
        reset_n = 1'b0;
        joy_in = '0;
        tick();
        testsRun++;
        if (ctl_n !== 16'hFFFF) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_abort: got %h, expected %h", ctl_n, 16'hFFFF);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (ctl_n !== 16'hFFFF) begin
                testsFailed++;
                $display("[TB] FAIL no_residual cycle %0d: got %h, expected %h", i, ctl_n, 16'hFFFF);
            end
        end
        dial_en = '0;
    endtask

    task automatic test_random();
        logic [8:0] codes [18] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h014,
                                   9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036,
                                   9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h0AA};
        applyReset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0)
                joy_in = joy_in ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0)
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 17)]};
            else if ($urandom_range(0, 7) == 0)
                ps2_key[9:0] = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 39) == 0) share_joy = ~share_joy;
            if ($urandom_range(0, 49) == 0) dial_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) dial_rev = 2'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 149) != 0);
            tick();
            testsRun++;
            if (ctl_n !== mExp) begin
                testsFailed++;
                $display("[TB] FAIL random cycle %0d: got %h, expected %h", c, ctl_n, mExp);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_key_latency();
        test_share();
        test_coin();
        test_dial();
        test_dial_both();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/arcade_ctrl_mux.md
# arcade_ctrl_mux

Parametrised player-control front end for arcade cores. Sits between `hps_io` (PS/2 key events, per-player joystick words) and the game core's active-low input ports. It replaces per-core ad-hoc key decoding with one registered block. It supports 1–4 players, a shared or split joystick mode, and per-player spinner (quadrature dial) emulation from up/down. Coin inputs get pulse stretching so short taps are never missed by the game CPU.

## Interface
Parameters:
- `PLAYERS`, 2, number of player channels, 1..4.
- `DIAL_DIV`, 12000, clk_sys cycles per dial phase step while a direction is held (≥2).
- `COIN_PULSE`, 120000, minimum coin assertion length in clk_sys cycles (≥1).

Ports (one clock; reset is synchronous and active-low):
- `clk_sys` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `ps2_key` in 11: {toggle, pressed, ext, code[7:0]} from hps_io.
- `joy_in` in 16*PLAYERS: joystick p in bits [16p+15:16p]. Bit map: 0 right, 1 left, 2 down, 3 up, 4 fire1, 5 fire2, 6 start1, 7 start2, 8 coin.
- `share_joy` in 1: 1 = every player sees the OR of all joysticks; 0 = each player sees only its own.
- `dial_en` in PLAYERS: per-player spinner mode.
- `dial_rev` in PLAYERS: per-player dial direction reversal.
- `ctl_n` out 8*PLAYERS: player p byte, active-low. Bit map: 7 fire1, 6 down/dialA, 5 up/dialB, 4 right, 3 left, 2 start, 1 fire2, 0 coin.

## Operation
- Key capture: latch `ps2_key[10]` each cycle. When the latched value differs from the current value, decode `{ext,code}` and write `pressed` into the matching key register. Unlisted codes are ignored.
  - P1 keys: E075 up, E072 down, E06B left, E074 right, 029 fire1, 014 fire2.
  - Start keys: 005/016 start1, 006/01E start2.
  - Coin keys: 02E coin1, 036 coin2.
  - P2 keys: 02D up, 02B down, 023 left, 034 right, 01C fire1.
  - Players 3–4 have no keys.
- Joystick source per player: `share_joy` ? OR of all `joy_in` words : own word.
- Direction and fire logic: each is key OR joystick bit. Fire2 for P2 is joystick only.
- Start logic:
  - P1 = start1 key | any joystick bit6.
  - P2 = start2 key | any joystick bit7.
  - P3/P4 = own bit6.
- Coin raw logic:
  - P1 = coin1 key | P1-source bit8.
  - P2 = coin2 key | P2-source bit8.
  - P3/P4 = own bit8.
- Coin stretcher, per player, counter-based:
  - A rising edge of raw coin while idle loads COIN_PULSE−1 and asserts coin.
  - Coin stays asserted while count>0 or raw is high.
  - Edges while active are ignored; there is no restart.
- Dial mode (`dial_en[p]=1`):
  - Bits 6:5 carry a 2-bit Gray phase, not inverted.
  - Up (XOR `dial_rev`) steps forward: 11→10→00→01→11. Down steps backward.
  - A per-player divider counts while exactly one of up/down is held. Each time it reaches DIAL_DIV−1 it wraps to 0 and the phase steps once.
  - Both or neither held: divider clears to 0 and the phase holds.
  - The first step occurs DIAL_DIV cycles after the press.
- Normal mode: bits 6:5 = ~{down, up}. The phase register holds its value; the divider is held at 0.
- Mode change mid-hold: divider clears and the phase is retained.

## Timing
- Reset (`reset_n`=0 at an edge):
  - All key registers and coin stretchers cleared; dividers 0; phases 2'b11.
  - `ctl_n` = all ones next cycle (dial players show phase 11 = all ones).
- Latency from ps2_key toggle to `ctl_n`: 2 cycles (key register, then output register).
- Latency from `joy_in` or `share_joy` to `ctl_n`: 1 cycle.
- Coin low duration for a single-cycle raw pulse: exactly COIN_PULSE cycles.
- Reset asserted mid-stretch or mid-dial-step aborts immediately; no residual pulse.
- Simultaneous key toggle and reset: reset wins.

## Test plan
- Reset, then toggle ps2_key with {pressed=1, code=0x029}: `ctl_n[7]` goes 0 two cycles later. Release event: returns to 1 two cycles after that.
- PLAYERS=2, `share_joy`=0: joy_in P2 bit0=1 gives `ctl_n[12]`=0 and `ctl_n[4]`=1. With `share_joy`=1, both go 0.
- COIN_PULSE=5, one-cycle pulse on joy_in bit8: `ctl_n[0]` low for exactly 5 cycles. A second pulse 2 cycles in does not extend it.
- DIAL_DIV=4, dial_en[0]=1, up held for 16 cycles: bits 6:5 go 11→10→00→01→11 at cycles 4, 8, 12, 16. With dial_rev=1 the sequence reverses.
- Hold up and down together with dial mode on: phase frozen and divider 0. Release down: first step 4 cycles later.
- Assert `reset_n`=0 mid-coin and mid-dial: next cycle `ctl_n`=16'hFFFF and phases 11.
